// File: rtl/ahfp_sub_arbiter.sv
// ============================================================================
// Module      : ahfp_sub_arbiter (with its ahfp_sub datapath)
// Description : Shares one single-precision subtractor among NUM_REQ
//               requesters. Valid/ready grant (round-robin by default),
//               operand register, combinational ahfp_sub, SUB_LAT result
//               stages and a one-hot tagged response.
//               Build option AHFP_SUB_ARB_FIXED_PRIO_EN: when defined the
//               lowest asserted requester always wins (pointer held at 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// ahfp_sub: combinational IEEE-754 single subtract, result = dataa - datab,
// round to nearest even, subnormals supported, quiet NaN 7FC00000.
// ----------------------------------------------------------------------------
module ahfp_sub (
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  logic        sa, sb, sx, sy, rsign, a_ge;
  logic        a_nan, b_nan, a_inf, b_inf, rnd_up, found;
  logic [9:0]  ea, eb, ex, ey, dshift, e_norm, e_field, lim, lz, sh;
  logic [23:0] ma, mb, mx, my;
  logic [49:0] y_shift;
  logic [26:0] xa, ya, diff, norm;
  logic [27:0] sum;
  logic [30:0] rounded;

  // Align, add/subtract magnitudes, normalise, round, then override specials
  always_comb begin
    sa      = dataa[31];
    sb      = ~datab[31];
    a_nan   = (&dataa[30:23]) && (|dataa[22:0]);
    b_nan   = (&datab[30:23]) && (|datab[22:0]);
    a_inf   = (&dataa[30:23]) && !(|dataa[22:0]);
    b_inf   = (&datab[30:23]) && !(|datab[22:0]);
    // Subnormals use exponent 1 with a zero hidden bit
    ea      = (dataa[30:23] == 8'd0) ? 10'd1 : {2'b00, dataa[30:23]};
    eb      = (datab[30:23] == 8'd0) ? 10'd1 : {2'b00, datab[30:23]};
    ma      = {|dataa[30:23], dataa[22:0]};
    mb      = {|datab[30:23], datab[22:0]};
    a_ge    = (dataa[30:0] >= datab[30:0]);
    sx      = a_ge ? sa : sb;
    sy      = a_ge ? sb : sa;
    ex      = a_ge ? ea : eb;
    ey      = a_ge ? eb : ea;
    mx      = a_ge ? ma : mb;
    my      = a_ge ? mb : ma;
    dshift  = ex - ey;
    y_shift = {my, 26'd0} >> dshift;
    // Three extra bits: guard, round, sticky
    xa      = {mx, 3'b000};
    ya      = {y_shift[49:24], |y_shift[23:0]};
    sum     = '0;
    diff    = '0;
    lz      = '0;
    lim     = '0;
    sh      = '0;
    found   = 1'b0;
    norm    = '0;
    e_norm  = ex;
    rsign   = sx;
    if (sx == sy) begin
      sum = {1'b0, xa} + {1'b0, ya};
      if (sum[27]) begin
        norm   = {sum[27:2], |sum[1:0]};
        e_norm = ex + 10'd1;
      end else begin
        norm   = sum[26:0];
      end
    end else begin
      diff = xa - ya;
      for (int k = 26; k >= 0; k--) begin
        if (!found && diff[k]) begin
          lz    = 10'(26 - k);
          found = 1'b1;
        end
      end
      // Never shift below the minimum exponent: the result goes subnormal
      lim    = ex - 10'd1;
      sh     = (lz > lim) ? lim : lz;
      norm   = diff << sh;
      e_norm = ex - sh;
      rsign  = (diff == 27'd0) ? 1'b0 : sx;
    end
    e_field = norm[26] ? e_norm : 10'd0;
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Rounding carry ripples naturally into the exponent field
    rounded = {e_field[7:0], norm[25:3]} + {30'd0, rnd_up};
    if (e_field >= 10'd255) begin
      result = {rsign, 8'hFF, 23'd0};
    end else begin
      result = {rsign, rounded};
    end
    if (a_nan || b_nan) begin
      result = 32'h7FC0_0000;
    end else if (a_inf && b_inf) begin
      result = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC0_0000;
    end else if (a_inf) begin
      result = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      result = {sb, 8'hFF, 23'd0};
    end
  end

endmodule

// ----------------------------------------------------------------------------
// ahfp_sub_arbiter: grant, operand stage, shared subtractor, result pipeline
// ----------------------------------------------------------------------------
module ahfp_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SUB_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_dataa,
  input  logic [32*NUM_REQ-1:0]  req_datab,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_result
);

  localparam int TAG_W = $clog2(NUM_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  tag_t              ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  tag_t              grant_idx;
  logic              grant_any;
  logic [TAG_W:0]    scan_sum;
  logic [TAG_W:0]    ptr_nxt;

  logic [31:0]       s0_a_q, s0_a_d, s0_b_q, s0_b_d;
  tag_t              s0_tag_q, s0_tag_d;
  logic              s0_vld_q, s0_vld_d;

  logic [31:0]       sub_out;

  logic [31:0]       res_q [SUB_LAT];
  logic [31:0]       res_d [SUB_LAT];
  tag_t              tag_q [SUB_LAT];
  tag_t              tag_d [SUB_LAT];
  logic              vld_q [SUB_LAT];
  logic              vld_d [SUB_LAT];

  // Grant the first valid requester scanning upward from the pointer
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      scan_sum = {1'b0, ptr_q} + (TAG_W+1)'(j);
      if (scan_sum >= (TAG_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (TAG_W+1)'(NUM_REQ);
      end
      if (!grant_any && req_valid[scan_sum[TAG_W-1:0]]) begin
        grant[scan_sum[TAG_W-1:0]] = 1'b1;
        grant_idx                  = scan_sum[TAG_W-1:0];
        grant_any                  = 1'b1;
      end
    end
    // No transfer can happen while reset is asserted
    if (reset) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;

  // Priority pointer: one past the winner, held when idle
  always_comb begin
    ptr_nxt = '0;
    ptr_d   = ptr_q;
`ifdef AHFP_SUB_ARB_FIXED_PRIO_EN
    ptr_d   = '0;
`else
    if (grant_any) begin
      ptr_nxt = {1'b0, grant_idx} + (TAG_W+1)'(1);
      if (ptr_nxt >= (TAG_W+1)'(NUM_REQ)) begin
        ptr_nxt = '0;
      end
      ptr_d = ptr_nxt[TAG_W-1:0];
    end
`endif
  end

  // Stage 0 captures the granted operands and tag
  always_comb begin
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    s0_tag_d = s0_tag_q;
    s0_vld_d = grant_any;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        s0_a_d = req_dataa[32*j +: 32];
        s0_b_d = req_datab[32*j +: 32];
      end
    end
    if (grant_any) begin
      s0_tag_d = grant_idx;
    end
  end

  ahfp_sub u_sub (
    .dataa  (s0_a_q),
    .datab  (s0_b_q),
    .result (sub_out)
  );

  // Result pipeline shifts subtractor output, tag and valid every cycle
  always_comb begin
    res_d[0] = sub_out;
    tag_d[0] = s0_tag_q;
    vld_d[0] = s0_vld_q;
    for (int k = 1; k < SUB_LAT; k++) begin
      res_d[k] = res_q[k-1];
      tag_d[k] = tag_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
  end

  // State registers with synchronous reset discarding in-flight work
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      s0_tag_q <= '0;
      s0_vld_q <= 1'b0;
      for (int k = 0; k < SUB_LAT; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
        vld_q[k] <= 1'b0;
      end
    end else begin
      ptr_q    <= ptr_d;
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      s0_tag_q <= s0_tag_d;
      s0_vld_q <= s0_vld_d;
      for (int k = 0; k < SUB_LAT; k++) begin
        res_q[k] <= res_d[k];
        tag_q[k] <= tag_d[k];
        vld_q[k] <= vld_d[k];
      end
    end
  end

  // One-hot response decoded from the last-stage tag
  always_comb begin
    rsp_valid = '0;
    if (vld_q[SUB_LAT-1]) begin
      rsp_valid[tag_q[SUB_LAT-1]] = 1'b1;
    end
    rsp_result = res_q[SUB_LAT-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_ahfp_sub_arbiter.sv
// ============================================================================
// Module      : tb_ahfp_sub_arbiter
// Description : Directed and randomised bench for ahfp_sub_arbiter with a
//               behavioural grant/response model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahfp_sub_arbiter;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [32*N-1:0]  req_dataa = '0;
  logic [32*N-1:0]  req_datab = '0;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_result;

  logic [31:0]      exp_res [N];
  int               tests = 0;
  int               fails = 0;

  logic [N-1:0]     got_ready, got_rv;
  logic [31:0]      got_res;

  always #5 clk = ~clk;

  ahfp_sub_arbiter #(.NUM_REQ(N), .SUB_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dataa  (req_dataa),
    .req_datab  (req_datab),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result)
  );

  // Exact float encoding of n * 2^e (|n| < 2^24)
  function automatic logic [31:0] fp_of(longint n, int e);
    logic        s;
    longint      m;
    int          msb;
    logic [63:0] mm;
    if (n == 0) return 32'h0;
    s   = (n < 0);
    m   = s ? -n : n;
    msb = 0;
    for (int k = 0; k < 40; k++) if ((m >> k) != 0) msb = k;
    mm  = 64'(m) << (23 - msb);
    return {s, 8'(127 + msb + e), mm[22:0]};
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    req_dataa[32*i +: 32] = a;
    req_datab[32*i +: 32] = b;
    exp_res[i] = e;
  endtask

  function automatic longint rand_int();
    int     w;
    longint m;
    w = $urandom_range(0, 22);
    m = longint'($urandom_range(0, 1 << w));
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  task automatic rand_op(input int i);
    longint a, b;
    int     e;
    a = rand_int();
    b = rand_int();
    e = int'($urandom_range(0, 40)) - 20;
    set_op(i, fp_of(a, e), fp_of(b, e), fp_of(a - b, e));
  endtask

  task automatic step();
    @(negedge clk);
    got_ready = req_ready;
    got_rv    = rsp_valid;
    got_res   = rsp_result;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic         m_vld [LAT+1];
  logic [N-1:0] m_oh  [LAT+1];
  logic [31:0]  m_res [LAT+1];
  int           m_ptr = 0;
  bit           m_started = 1'b0;
  bit           m_clean = 1'b1;

  function automatic int model_grant(logic [N-1:0] v, int p);
    for (int j = 0; j < N; j++) begin
      if (v[(p + j) % N]) return (p + j) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int           g;
    logic [N-1:0] exp_g;
    if (m_started) begin
      check32("rsp_valid", 32'(rsp_valid), m_vld[LAT] ? 32'(m_oh[LAT]) : 32'h0);
      if (m_vld[LAT]) check32("rsp_result", rsp_result, m_res[LAT]);
      else if (m_clean) check32("rsp_result_idle", rsp_result, 32'h0);
    end
    g     = reset ? -1 : model_grant(req_valid, m_ptr);
    exp_g = (g < 0) ? '0 : (N'(1) << g);
    if (m_started || reset) check32("req_ready", 32'(req_ready), 32'(exp_g));
    if (reset) begin
      for (int k = 0; k <= LAT; k++) m_vld[k] = 1'b0;
      m_ptr     = 0;
      m_clean   = 1'b1;
      m_started = 1'b1;
    end else begin
      for (int k = LAT; k > 0; k--) begin
        m_vld[k] = m_vld[k-1];
        m_oh[k]  = m_oh[k-1];
        m_res[k] = m_res[k-1];
      end
      m_vld[0] = (g >= 0);
      if (g >= 0) begin
        m_oh[0]  = exp_g;
        m_res[0] = exp_res[g];
        m_clean  = 1'b0;
`ifdef AHFP_SUB_ARB_FIXED_PRIO_EN
        m_ptr    = 0;
`else
        m_ptr    = (g + 1) % N;
`endif
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    logic [N-1:0] gr [10];
    logic [N-1:0] rv [10];
    logic [31:0]  rs [10];
    logic [N-1:0] exp_oh;

    // Reset held with every request asserted
    reset = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
    repeat (3) begin
      step();
      check32("reset_ready", 32'(got_ready), 32'h0);
    end
    reset = 1'b0;
    req_valid = '0;
    repeat (3) begin
      step();
      check32("post_reset_rsp_valid", 32'(got_rv), 32'h0);
      check32("post_reset_result", got_res, 32'h0);
    end

    // Single request from requester 0
    set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
    req_valid = 4'b0001;
    step();
    check32("single_ready", 32'(got_ready), 32'h1);
    req_valid = '0;
    step();
    check32("single_early", 32'(got_rv), 32'h0);
    step();
    check32("single_rsp_valid", 32'(got_rv), 32'h1);
    check32("single_result", got_res, 32'hBF80_0000);

    // All four requesters contend
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 32'h4040_0000, 32'h4060_0000, 32'hBF00_0000);
    req_valid = '1;
    for (int t = 0; t < 10; t++) begin
      step();
      gr[t] = got_ready;
      rv[t] = got_rv;
      rs[t] = got_res;
      if (t == 7) req_valid = '0;
    end
    for (int t = 0; t < 8; t++) begin
`ifdef AHFP_SUB_ARB_FIXED_PRIO_EN
      exp_oh = 4'b0001;
`else
      exp_oh = 4'b0001 << (t % 4);
`endif
      check32("rr_grant", 32'(gr[t]), 32'(exp_oh));
      check32("rr_rsp_tag", 32'(rv[t+2]), 32'(exp_oh));
      check32("rr_result", rs[t+2], 32'hBF00_0000);
    end

    // Back-to-back from requester 2
    set_op(2, 32'h4000_0000, 32'h4080_0000, 32'hC000_0000);
    req_valid = 4'b0100;
    step();
    check32("b2b_grant0", 32'(got_ready), 32'h4);
    set_op(2, 32'h43FA_0000, 32'h4113_3333, 32'h43F5_6666);
    step();
    check32("b2b_grant1", 32'(got_ready), 32'h4);
    req_valid = '0;
    step();
    check32("b2b_rsp0_valid", 32'(got_rv), 32'h4);
    check32("b2b_rsp0", got_res, 32'hC000_0000);
    step();
    check32("b2b_rsp1_valid", 32'(got_rv), 32'h4);
    check32("b2b_rsp1", got_res, 32'h43F5_6666);

    // Reset one cycle after a transfer
    set_op(0, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) begin
      step();
      check32("midreset_no_rsp", 32'(got_rv), 32'h0);
    end
    set_op(1, 32'h4000_0000, 32'h4000_0000, 32'h0);
    set_op(3, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b1010;
    step();
    check32("midreset_ptr0", 32'(got_ready), 32'h2);
    req_valid = 4'b1000;
    step();
    check32("midreset_then3", 32'(got_ready), 32'h8);
    req_valid = '0;

`ifdef AHFP_SUB_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 3 starves while 0 is valid
    set_op(0, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000);
    set_op(3, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b1001;
    repeat (5) begin
      step();
      check32("fixed_grant0", 32'(got_ready), 32'h1);
    end
    req_valid = 4'b1000;
    step();
    check32("fixed_grant3", 32'(got_ready), 32'h8);
    req_valid = '0;
`endif

    // Randomised traffic with varying load and occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int load;
      load = (cyc / 500) % 3;
      step();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && got_ready[i]) begin
          if (load == 2 || $urandom_range(0, 1) == 1) rand_op(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && ($urandom_range(0, 3) < load + 1)) begin
          rand_op(i);
          req_valid[i] = 1'b1;
        end
      end
      reset = ($urandom_range(0, 149) == 0);
    end
    reset = 1'b0;
    req_valid = '0;
    repeat (LAT + 4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
